// File: rtl/abs_diff_arbiter.sv
// Round-robin arbiter sharing one |a-b| datapath between NUM_REQ requesters; results tagged with requester id.
// Latency: accepted on edge t, result register valid after edge t+1; one result per cycle sustained.
// Backpressure: res_valid && !res_ready freezes both stages and forces req_ready to zero.
module abs_diff_arbiter #(
    parameter int pixelBitWidth = 14,
    parameter int NUM_REQ       = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*pixelBitWidth-1:0] req_a,
    input  logic [NUM_REQ*pixelBitWidth-1:0] req_b,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [pixelBitWidth-2:0]         res_data,
    output logic [2:0]                       res_id,
    output logic                             busy
);
    localparam int W   = pixelBitWidth;
    localparam int IDW = (NUM_REQ > 4) ? 3 : ((NUM_REQ > 2) ? 2 : 1);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic           advance;
    logic           xfer;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;

    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [IDW-1:0] s1_id;
    logic           s2_valid;
    logic [W-2:0]   s2_data;
    logic [IDW-1:0] s2_id;

    logic [W-1:0]   diff;
    logic [W-1:0]   mag;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NUM_REQ))
                cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
            cand = cand_sum[IDW-1:0];
            if (req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign advance = !(s2_valid && !res_ready);
    // Gating with rst_n keeps req_ready low while reset is held.
    assign xfer    = gnt_vld && advance && rst_n;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                req_ready[i] = xfer;
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
            end
        end
    end

    assign diff = s1_a - s1_b;
    assign mag  = diff[W-1] ? (~diff + 1'b1) : diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else if (advance) begin
            if (xfer)
                ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            s1_valid <= xfer;
            s1_a     <= a_sel;
            s1_b     <= b_sel;
            s1_id    <= gnt_idx;
            s2_valid <= s1_valid;
            s2_data  <= mag[W-2:0];
            s2_id    <= s1_id;
        end
    end

    always_comb begin
        res_id          = '0;
        res_id[IDW-1:0] = s2_id;
    end

    assign res_valid = s2_valid;
    assign res_data  = s2_data;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_abs_diff_arbiter.sv
// Randomized and directed bench for abs_diff_arbiter (NUM_REQ=4 main instance, NUM_REQ=2 side instance).
module tb_abs_diff_arbiter;
    localparam int W = 14;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-2:0]   res_data;
    logic [2:0]     res_id;
    logic           busy;

    logic [1:0]     v2;
    logic [1:0]     rdy2;
    logic [2*W-1:0] a2;
    logic [2*W-1:0] b2;
    logic           rv2;
    logic           rr2;
    logic [W-2:0]   rd2;
    logic [2:0]     rid2;
    logic           busy2;

    abs_diff_arbiter #(.pixelBitWidth(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    abs_diff_arbiter #(.pixelBitWidth(W), .NUM_REQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2),
        .res_valid(rv2), .res_ready(rr2),
        .res_data(rd2), .res_id(rid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct { int id; int data; } res_t;
    res_t q[$];
    int   id_log[$];
    bit   log_en = 1'b0;
    int   mptr = 0;
    bit   m1 = 1'b0;
    bit   m2 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // |a-b| in W-bit two's complement, truncated to W-1 bits.
    function automatic int ref_abs(input int a, input int b);
        int d;
        d = a - b;
        if (d < 0) d += (1 << W);
        if (d >= (1 << (W-1))) d = (1 << W) - d;
        return d % (1 << (W-1));
    endfunction

    function automatic int pick(input logic [31:0] v, input int p, input int n);
        for (int k = 0; k < n; k++)
            if (v[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    function automatic int rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 0;
            1: return 8191;
            2: return 8192;
            3: return 16383;
            default: return $urandom_range(0, 16383);
        endcase
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_ops(i, rand_op(), rand_op());
    endtask

    // One clock: compare outputs at negedge against the model, then advance the model.
    task automatic cycle();
        int  g;
        bit  adv;
        int  exp_rdy;
        @(negedge clk);
        g       = pick(32'(req_valid), mptr, N);
        adv     = !(m2 && !res_ready);
        exp_rdy = (g >= 0 && adv) ? (1 << g) : 0;
        check("req_ready", 32'(req_ready), exp_rdy);
        check("res_valid", 32'(res_valid), 32'(m2));
        check("busy", 32'(busy), 32'(m1 | m2));
        if (m2 && q.size() > 0) begin
            check("res_data", 32'(res_data), q[0].data);
            check("res_id", 32'(res_id), q[0].id);
        end
        if (m2 && res_ready && q.size() > 0) begin
            if (log_en) id_log.push_back(q[0].id);
            void'(q.pop_front());
        end
        if (adv) begin
            m2 = m1;
            m1 = (g >= 0);
            if (g >= 0) begin
                q.push_back('{g, ref_abs(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]))});
                mptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int a, input int b, input int exp);
        req_valid = 4'(1 << i);
        set_ops(i, a, b);
        res_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        check("send_valid", 32'(res_valid), 1);
        check("send_data", 32'(res_data), exp);
        check("send_id", 32'(res_id), i);
        cycle();
    endtask

    task automatic model_reset();
        m1 = 1'b0;
        m2 = 1'b0;
        mptr = 0;
        q.delete();
    endtask

    initial begin
        logic [W-2:0] hold_d;
        logic [2:0]   hold_id;
        int           gh[$];
        int           p2;
        int           g2;

        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        v2        = '0;
        a2        = '0;
        b2        = '0;
        rr2       = 1'b1;
        #3;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        model_reset();

        // Directed single requests and arithmetic boundaries
        send(0, 100, 30, 70);
        send(0, 30, 100, 70);
        send(2, 16383, 0, 1);
        send(1, 8192, 0, 0);
        send(3, 0, 8191, 8191);
        send(0, 5, 5, 0);

        // Fairness: all requesters valid, strict rotation with no gaps
        req_valid = '1;
        res_ready = 1'b1;
        rand_ops();
        log_en = 1'b1;
        for (int c = 0; c < 8; c++) cycle();
        req_valid = '0;
        cycle();
        cycle();
        log_en = 1'b0;
        check("fair_count", id_log.size(), 8);
        for (int k = 1; k < id_log.size(); k++)
            check("fair_order", id_log[k], (id_log[k-1] + 1) % N);

        // Backpressure with requesters 1 and 3 streaming
        req_valid = 4'b1010;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin rand_ops(); cycle(); end
        res_ready = 1'b0;
        hold_d    = res_data;
        hold_id   = res_id;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            cycle();
            check("stall_data", 32'(res_data), 32'(hold_d));
            check("stall_id", 32'(res_id), 32'(hold_id));
        end
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin rand_ops(); cycle(); end
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();
        check("bp_drained", 32'(busy), 0);
        check("bp_queue", q.size(), 0);

        // Randomized traffic with random consumer stalls
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            cycle();
        end
        req_valid = '0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        check("rand_drained", q.size(), 0);

        // Reset with both stages full
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin rand_ops(); cycle(); end
        res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(res_valid), 0);
        check("mid_rst_data", 32'(res_data), 0);
        check("mid_rst_id", 32'(res_id), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        req_valid = 4'b1010;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0010);
        for (int c = 0; c < 4; c++) begin rand_ops(); cycle(); end
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();

        // Two-requester instance: idle requester skipped, pointer wraps
        p2 = 0;
        for (int c = 0; c < 12; c++) begin
            v2 = (c < 4) ? 2'b10 : ((c < 8) ? 2'b01 : 2'b11);
            a2 = {W'($urandom_range(0, 16383)), W'($urandom_range(0, 16383))};
            b2 = {W'($urandom_range(0, 16383)), W'($urandom_range(0, 16383))};
            @(negedge clk);
            g2 = pick(32'(v2), p2, 2);
            check("n2_ready", 32'(rdy2), (g2 >= 0) ? (1 << g2) : 0);
            if (c >= 2) begin
                check("n2_valid", 32'(rv2), 32'(gh[c-2] >= 0));
                if (gh[c-2] >= 0) check("n2_id", 32'(rid2), gh[c-2]);
            end
            gh.push_back(g2);
            if (g2 >= 0) p2 = (g2 + 1) % 2;
            @(posedge clk);
            #1;
        end
        v2 = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
